// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: guaranteed scanout read slot on each pixel strobe,
// queued pixel writes fill the other cycles. Optional stats: VGA_FB_ARB_STATS_EN.
module vga_fb_arbiter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              pix_en,
    input  logic              pix_valid,
    input  logic [15:0]       pix_x,
    input  logic [15:0]       pix_y,
    output logic [11:0]       color,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [15:0]       wr_x,
    input  logic [15:0]       wr_y,
    input  logic [11:0]       wr_color,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
    ,
    output logic [15:0]              wr_drops,
    output logic [$clog2(QDEPTH):0]  q_max
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [15:0] x,
                                                  input logic [15:0] y);
        logic [32:0] full;
        full = 33'(y) * 33'(WIDTH) + 33'(x);
        return full[ADDR_W-1:0];
    endfunction

    logic [ADDR_W-1:0] qaddr_q [QDEPTH];
    logic [11:0]       qdata_q [QDEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ready_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [11:0]       last_wdata_q;
    logic              pend_q, pend_rd_q;
    logic [11:0]       color_q;

    logic disp, blank, do_pop, accept, in_range, do_push;

    // Slot classification and queue handshake for this cycle
    always_comb begin
        disp     = pix_en & pix_valid;
        blank    = pix_en & ~pix_valid;
        do_pop   = ~disp & (count_q != '0);
        accept   = wr_valid & ready_q;
        in_range = (wr_x < 16'(WIDTH)) && (wr_y < 16'(HEIGHT));
        do_push  = accept & in_range;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    end

    // RAM port mux: scanout read wins, else queue head, else hold address
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = last_addr_q;
        mem_wdata = last_wdata_q;
        if (res) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (disp) begin
            mem_addr = addr_of(pix_x, pix_y);
        end else if (do_pop) begin
            mem_we    = 1'b1;
            mem_addr  = qaddr_q[rd_ptr_q];
            mem_wdata = qdata_q[rd_ptr_q];
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (do_push) begin
            qaddr_q[wr_ptr_q] <= addr_of(wr_x, wr_y);
            qdata_q[wr_ptr_q] <= wr_color;
        end
    end

    // Queue pointers, registered ready and held RAM-port values
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ready_q      <= (count_d < CW'(QDEPTH));
            last_addr_q  <= mem_addr;
            last_wdata_q <= mem_wdata;
        end
    end

    // Two-stage color pipeline: strobe marks pending, next edge loads color
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pend_q    <= 1'b0;
            pend_rd_q <= 1'b0;
            color_q   <= '0;
        end else begin
            pend_q    <= disp | blank;
            pend_rd_q <= disp;
            if (pend_q) begin
                color_q <= pend_rd_q ? mem_rdata : 12'h000;
            end
        end
    end

    assign wr_ready = ready_q;
    assign color    = color_q;

`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] drops_q;
    logic [CW-1:0] qmax_q;

    // Saturating drop counter and occupancy high-water mark
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            drops_q <= '0;
            qmax_q  <= '0;
        end else begin
            if (accept && !in_range && drops_q != 16'hFFFF) begin
                drops_q <= drops_q + 16'd1;
            end
            if (count_d > qmax_q) begin
                qmax_q <= count_d;
            end
        end
    end

    assign wr_drops = drops_q;
    assign q_max    = qmax_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter with a queue/shadow-RAM reference model.
// Build with +define+VGA_FB_ARB_STATS_EN to also check the stats ports.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        res;
    logic        pix_en, pix_valid;
    logic [15:0] pix_x, pix_y;
    logic [11:0] color;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_x, wr_y;
    logic [11:0] wr_color;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] wr_drops;
    logic [2:0]  q_max;
`endif

    vga_fb_arbiter dut (
        .clk       (clk),
        .res       (res),
        .pix_en    (pix_en),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .color     (color),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_color  (wr_color),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef VGA_FB_ARB_STATS_EN
        ,
        .wr_drops  (wr_drops),
        .q_max     (q_max)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read returns contents before any same-edge write
    logic [11:0] tbram [0:524287];
    always @(posedge clk) begin
        mem_rdata <= tbram[mem_addr];
        if (mem_we) tbram[mem_addr] = mem_wdata;
    end

    typedef struct {
        int         addr;
        logic [11:0] c;
    } wr_t;

    wr_t         mq[$];
    logic [11:0] mram [int];
    logic        m_ready;
    logic [11:0] exp_color;
    logic        pend_v;
    logic [11:0] pend_val;
    int          last_addr;
    int          m_drops;
    int          m_qmax;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] mread(input int a);
        return mram.exists(a) ? mram[a] : 12'h000;
    endfunction

    task automatic step(input logic r, input logic pe, input logic pv,
                        input logic [15:0] px, input logic [15:0] py,
                        input logic wv, input logic [15:0] wx,
                        input logic [15:0] wy, input logic [11:0] wc);
        int    a;
        wr_t   e;
        logic  [11:0] rd;
        @(negedge clk);
        res = r; pix_en = pe; pix_valid = pv; pix_x = px; pix_y = py;
        wr_valid = wv; wr_x = wx; wr_y = wy; wr_color = wc;
        #1;
        if (r) begin
            check("rst_color", color, 0);
            check("rst_we", mem_we, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_ready", wr_ready, 0);
            mq.delete();
            m_ready = 0; exp_color = 0; pend_v = 0; pend_val = 0;
            last_addr = 0; m_drops = 0; m_qmax = 0;
            return;
        end
        check("ready", wr_ready, m_ready);
        check("color", color, exp_color);
        rd = 12'h000;
        if (pe && pv) begin
            a = int'(py) * 640 + int'(px);
            check("disp_we", mem_we, 0);
            check("disp_addr", mem_addr, a);
            rd = mread(a);
            last_addr = a;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            check("wr_we", mem_we, 1);
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.c);
            mram[e.addr] = e.c;
            last_addr = e.addr;
        end else begin
            check("idle_we", mem_we, 0);
            check("idle_addr", mem_addr, last_addr);
        end
        if (wv && m_ready) begin
            if (wx < 640 && wy < 480) begin
                e.addr = int'(wy) * 640 + int'(wx);
                e.c = wc;
                mq.push_back(e);
            end else begin
                m_drops++;
            end
        end
        if (mq.size() > m_qmax) m_qmax = mq.size();
        m_ready = (mq.size() < 4);
        if (pend_v) exp_color = pend_val;
        pend_v = pe;
        pend_val = rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_stats();
`ifdef VGA_FB_ARB_STATS_EN
        check("wr_drops", wr_drops, m_drops);
        check("q_max", q_max, m_qmax);
`endif
    endtask

    initial begin
        int   k;
        logic pe, pv, wv, prev_pe;
        logic [15:0] px, py, wx, wy;
        for (int i = 0; i < 524288; i++) tbram[i] = 12'h000;
        tbram[1283] = 12'hABC;
        mram[1283] = 12'hABC;
        res = 1; pix_en = 0; pix_valid = 0; pix_x = 0; pix_y = 0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_color = 0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Display read at (3,2), color arrives two cycles later
        step(0, 1, 1, 3, 2, 0, 0, 0, 0);
        idle(2);
        check("t1_color", color, 12'hABC);

        // Blank strobe gives color 0 and carries a queued write
        step(0, 0, 0, 0, 0, 1, 10, 1, 12'h123);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("t2_we", mem_we, 1);
        idle(2);
        check("t2_color", color, 0);

        // Six back-to-back writes with scanout busy every other cycle
        k = 0;
        for (int i = 0; i < 40 && k < 6; i++) begin
            logic acc;
            acc = m_ready;
            step(0, (i % 2) == 0, 1, 16'(i), 3, 1, 16'(k), 1,
                 12'h500 + 12'(k));
            if (acc) k++;
        end
        check("t3_accepted", k, 6);
        idle(8);
        check_stats();

        // Out-of-range writes complete the handshake but are dropped
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 640, 0, 12'hF00);
        step(0, 0, 0, 0, 0, 1, 0, 480, 12'h0F0);
        idle(3);
        check("t4_drops", m_drops, 2);
        check_stats();

        // Reset while three entries are queued
        k = 0;
        for (int i = 0; i < 40 && mq.size() < 3; i++) begin
            step(0, (i % 2) == 0, 1, 1, 1, 1, 16'(20 + i), 5, 12'hEEE);
        end
        check("t6_queued", mq.size(), 3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_we", mem_we, 0);
        check("t6_color", color, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(6);

        // Randomized traffic on a small region so reads and writes overlap
        prev_pe = 0;
        for (int i = 0; i < 4000; i++) begin
            pe = !prev_pe && ($urandom_range(0, 2) != 0);
            pv = ($urandom_range(0, 4) != 0);
            px = 16'($urandom_range(0, 15));
            py = 16'($urandom_range(0, 3));
            wv = ($urandom_range(0, 9) < 7);
            wx = 16'($urandom_range(0, 15));
            wy = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) wx = 16'($urandom_range(640, 65535));
            if ($urandom_range(0, 19) == 0) wy = 16'($urandom_range(480, 65535));
            step(0, pe, pv, px, py, wv, wx, wy, 12'($urandom));
            prev_pe = pe;
            if ((i % 1000) == 999) check_stats();
        end
        idle(10);
        check("final_empty", mq.size(), 0);
        check_stats();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
